// File: rtl/pad_game_pkg.sv
// Shared definitions for the pad game engine: FSM state encoding,
// scoring constants and the Galois LFSR feedback mask.
package pad_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PICK     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_SCORE    = 3'd3,
    ST_GAMEOVER = 3'd4
  } pad_game_state_e;

  localparam logic [3:0]  CENTRE_PTS = 4'd4;
  localparam logic [3:0]  RING_PTS   = 4'd2;
  localparam int          STREAK_MIN = 3;

  // Right-shifting Galois form of the x^16 + x^14 + x^13 + x^11 + 1 polynomial.
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/pad_game_lfsr.sv
// Free-running 16-bit Galois LFSR used to pick target pads.
module pad_game_lfsr
  import pad_game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Advance one step every cycle.
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  // State register, seeded on reset (seed must be non-zero).
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/pad_game_engine.sv
// Whack-a-pad game engine: arms one random pad at a time, scores hits on
// the armed pad's sensors, counts rounds and signals game over.
// Optional streak bonus is enabled by defining PAD_GAME_STREAK_EN.
// Handshake: iStart is a single-cycle request honoured only in IDLE or
// GAMEOVER; iAbort is a level that forces IDLE and overrides iStart.
module pad_game_engine
  import pad_game_pkg::*;
#(
  parameter int          NUM_PADS     = 3,
  parameter int          SENS_PER_PAD = 5,
  parameter int          TIMEOUT      = 20000000,
  parameter int          ROUNDS       = 20,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                             iVGA_CLK,
  input  logic                             iRST_n,
  input  logic                             iStart,
  input  logic                             iAbort,
  input  logic [NUM_PADS*SENS_PER_PAD-1:0] sensor_input,
  output logic [31:0]                      out_game,
  output logic [2:0]                       oPad,
  output logic [1:0]                       oPhase,
  output logic [15:0]                      oPoints,
  output logic [7:0]                       oRound,
  output logic                             oBusy,
  output logic                             oGameOver,
  output pad_game_state_e                  oDbgState
);

  localparam int          SW        = NUM_PADS * SENS_PER_PAD;
  localparam logic [31:0] LAST_CNT  = 32'(TIMEOUT - 1);
  localparam logic [31:0] PH1_LIMIT = 32'(TIMEOUT / 3);
  localparam logic [31:0] PH2_LIMIT = 32'((2 * TIMEOUT) / 3);
  localparam logic [8:0]  ROUNDS_L  = 9'(ROUNDS);
  // Every sensor of a pad except the centre (MSB) one.
  localparam logic [SENS_PER_PAD-1:0] RING_MASK =
    ~(SENS_PER_PAD'(1) << (SENS_PER_PAD - 1));

  pad_game_state_e state_q, state_d;
  logic [SW-1:0]   sync1_q, sync1_d;
  logic [SW-1:0]   sync2_q, sync2_d;
  logic [2:0]      pad_q, pad_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [15:0]     points_q, points_d;
  logic [7:0]      round_q, round_d;
  logic [3:0]      pend_pts_q, pend_pts_d;
`ifdef PAD_GAME_STREAK_EN
  logic            pend_hit_q, pend_hit_d;
  logic [7:0]      streak_q, streak_d;
  logic [7:0]      streak_inc;
`endif

  logic [15:0]             lfsr;
  logic [SENS_PER_PAD-1:0] grp;
  logic                    hit;
  logic                    centre_low;
  logic                    ring_low;
  logic [3:0]              hit_pts;
  logic [2:0]              pick_pad;
  logic [15:0]             add_pts;
  logic [16:0]             sum17;
  logic [15:0]             sat_points;

  pad_game_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (iVGA_CLK),
    .rst_n  (iRST_n),
    .lfsr_o (lfsr)
  );

  // Two-stage synchroniser for the asynchronous sensor lines.
  always_comb begin
    sync1_d = sensor_input;
    sync2_d = sync1_q;
  end

  // Hit detection and point value for the armed pad; next pad choice.
  always_comb begin
    grp        = sync2_q[int'(pad_q) * SENS_PER_PAD +: SENS_PER_PAD];
    hit        = ~&grp;
    centre_low = ~grp[SENS_PER_PAD-1];
    ring_low   = |(~grp & RING_MASK);
    hit_pts    = (centre_low ? CENTRE_PTS : 4'd0) + (ring_low ? RING_PTS : 4'd0);
    pick_pad   = 3'(lfsr % 16'(NUM_PADS));
    if (NUM_PADS > 1 && pick_pad == pad_q) begin
      pick_pad = (pick_pad == 3'(NUM_PADS - 1)) ? 3'd0 : pick_pad + 3'd1;
    end
  end

  // Saturating score update including the optional streak bonus.
  always_comb begin
    add_pts = {12'd0, pend_pts_q};
`ifdef PAD_GAME_STREAK_EN
    streak_inc = (streak_q == 8'hFF) ? streak_q : streak_q + 8'd1;
    if (pend_hit_q && streak_inc >= 8'(STREAK_MIN)) add_pts = add_pts + 16'd1;
`endif
    sum17      = {1'b0, points_q} + {1'b0, add_pts};
    sat_points = sum17[16] ? 16'hFFFF : sum17[15:0];
  end

  // Game FSM next-state and datapath updates; abort overrides everything.
  always_comb begin
    state_d    = state_q;
    pad_d      = pad_q;
    cnt_d      = cnt_q;
    points_d   = points_q;
    round_d    = round_q;
    pend_pts_d = pend_pts_q;
`ifdef PAD_GAME_STREAK_EN
    pend_hit_d = pend_hit_q;
    streak_d   = streak_q;
`endif
    if (iAbort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_GAMEOVER: begin
          if (iStart) begin
            state_d  = ST_PICK;
            points_d = 16'd0;
            round_d  = 8'd0;
`ifdef PAD_GAME_STREAK_EN
            streak_d = 8'd0;
`endif
          end
        end
        ST_PICK: begin
          pad_d   = pick_pad;
          cnt_d   = 32'd0;
          state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (hit) begin
            pend_pts_d = hit_pts;
`ifdef PAD_GAME_STREAK_EN
            pend_hit_d = 1'b1;
`endif
            state_d    = ST_SCORE;
          end else if (cnt_q == LAST_CNT) begin
            pend_pts_d = 4'd0;
`ifdef PAD_GAME_STREAK_EN
            pend_hit_d = 1'b0;
`endif
            state_d    = ST_SCORE;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_SCORE: begin
          points_d = sat_points;
          round_d  = round_q + 8'd1;
`ifdef PAD_GAME_STREAK_EN
          streak_d = pend_hit_q ? streak_inc : 8'd0;
`endif
          state_d  = (({1'b0, round_q} + 9'd1) == ROUNDS_L) ? ST_GAMEOVER : ST_PICK;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      state_q    <= ST_IDLE;
      sync1_q    <= '1;
      sync2_q    <= '1;
      pad_q      <= 3'd0;
      cnt_q      <= 32'd0;
      points_q   <= 16'd0;
      round_q    <= 8'd0;
      pend_pts_q <= 4'd0;
`ifdef PAD_GAME_STREAK_EN
      pend_hit_q <= 1'b0;
      streak_q   <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      pad_q      <= pad_d;
      cnt_q      <= cnt_d;
      points_q   <= points_d;
      round_q    <= round_d;
      pend_pts_q <= pend_pts_d;
`ifdef PAD_GAME_STREAK_EN
      pend_hit_q <= pend_hit_d;
      streak_q   <= streak_d;
`endif
    end
  end

  // Output decode from registered state.
  always_comb begin
    out_game  = 32'hFFFF_FFFF;
    oPhase    = 2'd0;
    if (state_q == ST_ARMED) begin
      out_game = ~(32'd1 << pad_q);
      if (cnt_q < PH1_LIMIT)      oPhase = 2'd1;
      else if (cnt_q < PH2_LIMIT) oPhase = 2'd2;
      else                        oPhase = 2'd3;
    end
    oPad      = pad_q;
    oPoints   = points_q;
    oRound    = round_q;
    oBusy     = (state_q == ST_PICK) || (state_q == ST_ARMED) || (state_q == ST_SCORE);
    oGameOver = (state_q == ST_GAMEOVER);
    oDbgState = state_q;
  end

endmodule

// File: doc/pad_game_engine.md
PAD_GAME_ENGINE -- requirements
Module: pad_game_engine

Interface
REQ-001 Parameter NUM_PADS, default 3: number of target pads (1..8).
REQ-002 Parameter SENS_PER_PAD, default 5: sensors per pad; the pad's MSB sensor is the centre sensor.
REQ-003 Parameter TIMEOUT, default 20000000: clock cycles a target stays armed before a miss.
REQ-004 Parameter ROUNDS, default 20: targets per game.
REQ-005 Parameter LFSR_SEED, default 16'hACE1: non-zero LFSR reset value.
REQ-006 iVGA_CLK  in  1  sole clock, rising edge.
REQ-007 iRST_n  in  1  reset, synchronous, active-low.
REQ-008 iStart  in  1  one-cycle pulse; starts a game from IDLE or GAMEOVER.
REQ-009 iAbort  in  1  level; returns to IDLE from any state.
REQ-010 sensor_input  in  NUM_PADS*SENS_PER_PAD  active-low hits; pad p occupies bits [p*SENS_PER_PAD +: SENS_PER_PAD].
REQ-011 out_game  out  32  active-low pad lamp drive: bit p low while pad p is armed, all other bits high.
REQ-012 oPad  out  3  index of the armed pad.
REQ-013 oPhase  out  2  animation phase of the armed target: 0 none, 1/2/3 thirds of TIMEOUT.
REQ-014 oPoints  out  16  running score.
REQ-015 oRound  out  8  completed round count.
REQ-016 oBusy  out  1  high in PICK, ARMED or SCORE.
REQ-017 oGameOver  out  1  high in GAMEOVER.

Function
REQ-018 FSM states: IDLE, PICK, ARMED, SCORE, GAMEOVER; one-hot or binary encoding is free.
REQ-019 Sensors SHALL pass through a 2-flop synchroniser; all decisions use the synchronised value (2-cycle input latency).
REQ-020 IDLE->PICK on iStart; oPoints, oRound and streak clear on the same edge.
REQ-021 The 16-bit Galois LFSR (taps 16,14,13,11) SHALL advance every cycle; PICK selects pad = LFSR mod NUM_PADS, goes to ARMED after 1 cycle.
REQ-022 The pad chosen SHALL differ from the previous pad when NUM_PADS>1; on a repeat, the pad index increments modulo NUM_PADS.
REQ-023 ARMED: cycle counter from 0; hit = armed pad group not all ones; hit->SCORE; counter==TIMEOUT-1 with no hit->SCORE as a miss; a hit on that same cycle counts as a hit.
REQ-024 Hits on non-armed pads SHALL be ignored.
REQ-025 Score per hit: +4 if centre sensor low, +2 if any non-centre sensor low, additive (both = +6).
REQ-026 oPoints SHALL saturate at 16'hFFFF.
REQ-027 SCORE lasts 1 cycle: apply points, oRound+1; go to GAMEOVER if oRound+1==ROUNDS, otherwise PICK.
REQ-028 oPhase = 1 while counter < TIMEOUT/3, 2 while < 2*TIMEOUT/3, else 3; oPhase is 0 outside ARMED.
REQ-029 out_game is all ones outside ARMED.
REQ-030 GAMEOVER holds oPoints and oRound; iStart restarts as from IDLE.
REQ-031 iAbort has priority over every transition, including iStart on the same edge.

Reset
REQ-032 On iRST_n low at a clock edge: state IDLE, out_game 32'hFFFFFFFF, oPad 0, oPhase 0, oPoints 0, oRound 0, oBusy 0, oGameOver 0, LFSR=LFSR_SEED, synchronisers all ones.
REQ-033 Reset mid-game SHALL discard the round with no partial score.

Configuration
REQ-034 With PAD_GAME_STREAK_EN defined: a streak counter counts consecutive hits; each hit with streak >= 3 (including this hit) adds +1 bonus; a miss clears the streak.
REQ-035 Without PAD_GAME_STREAK_EN: no streak register and no bonus; scoring is exactly REQ-025.

Structure
REQ-036 Package pad_game_pkg SHALL hold the state enum, score constants (CENTRE_PTS=4, RING_PTS=2, STREAK_MIN=3) and the LFSR tap constant.
REQ-037 Sub-module pad_game_lfsr SHALL implement the free-running LFSR (seed parameter, 16-bit output).

Verification
REQ-038 Reset, then iStart with no sensor activity -> 20 misses, each lasting TIMEOUT cycles (use TIMEOUT=30); oGameOver=1, oPoints=0, oRound=20.
REQ-039 Armed pad 1 with SPP=5: drive bits[9]=0 and [5]=0 -> +6; only bit[7]=0 -> +2; only bit[9]=0 -> +4.
REQ-040 Hit on a non-armed pad only -> no score, target times out, oRound+1, oPoints unchanged.
REQ-041 Hit on cycle TIMEOUT-1 -> scored as a hit; hit on TIMEOUT cycle after the miss -> ignored.
REQ-042 PAD_GAME_STREAK_EN defined, four consecutive centre hits -> 4,8,13,18; then a miss; then a centre hit -> 22.
REQ-043 iAbort and iStart on the same cycle mid-ARMED -> IDLE, out_game=32'hFFFFFFFF; iRST_n low mid-game -> all REQ-032 values.
